pc_seq: RTL

Parametrised program-counter sequencer, the successor to the fixed 32-bit PC register. Holds the current PC and selects the next one every enabled cycle: sequential step, branch, jump/call, return or exception. Includes an optional return-address stack (RAS). Sits at the head of the fetch stage and feeds the instruction memory address.

---
 rtl/pc_seq.sv | 98 +++++++++
 1 files changed

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer; define PC_RAS_EN to build the return-address stack.
module pc_seq #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter int          STEP      = 4,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             exc,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jmp_target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC = WIDTH'(EXC_VEC);

    if (RAS_DEPTH < 2 || RAS_DEPTH > 16) begin : g_bad_depth
        $error("pc_seq: RAS_DEPTH must be 2..16");
    end

    logic [WIDTH-1:0] seq, pc_next;

    assign seq = pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    wp, wp_inc, wp_dec;
    logic [CW-1:0]    cnt;
    logic             empty, full, push, pop, ovf, unf;

    assign empty  = cnt == '0;
    assign full   = cnt == CW'(RAS_DEPTH);
    assign wp_inc = wp == PW'(RAS_DEPTH - 1) ? '0 : wp + 1'b1;
    assign wp_dec = wp == '0 ? PW'(RAS_DEPTH - 1) : wp - 1'b1;
    // ret outranks call, so a simultaneous call never pushes
    assign pop  = ena && !exc && ret && !empty;
    assign push = ena && !exc && !ret && call;

    assign pc_next = exc ? EXC :
                     ret ? (empty ? seq : stack[wp_dec]) :
                     (call || jmp) ? jmp_target :
                     br_taken ? br_target : seq;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            wp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= push && full;
            unf <= ena && !exc && ret && empty;
            wp  <= push ? wp_inc : pop ? wp_dec : wp;
            cnt <= (push && !full) ? cnt + 1'b1 : pop ? cnt - 1'b1 : cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            stack[wp] <= seq;
    end

    assign ras_empty = empty;
    assign ras_full  = full;
    assign ras_ovf   = ovf;
    assign ras_unf   = unf;
`else
    assign pc_next = exc ? EXC :
                     (ret || call || jmp) ? jmp_target :
                     br_taken ? br_target : seq;

    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst)
            pc <= RST;
        else if (ena)
            pc <= pc_next;
    end
endmodule
